// File: rtl/alu_exec_unit.sv
// EX-stage ALU with RV32M: decodes aluop/funct3/funct7, executes, and
// returns results over a valid/ready handshake; divide is iterative.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            iClk,
  input  logic            iRstN,
  input  logic            iValid,
  output logic            oReady,
  input  logic [2:0]      iAluOp,
  input  logic [2:0]      iFunct3,
  input  logic [6:0]      iFunct7,
  input  logic [XLEN-1:0] iOpA,
  input  logic [XLEN-1:0] iOpB,
  input  logic            iFlush,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oResult,
  output logic            oBranchTaken,
  output logic            oIllegal
);

  localparam int SW = $clog2(XLEN);
  localparam bit HAS_M = (ENABLE_M != 0);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_PASSB, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_BR, OP_ILL
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_DIV
  } state_e;

  function automatic op_e base_op(input logic [2:0] f3);
    unique case (f3)
      3'b000: return OP_ADD;
      3'b001: return OP_SLL;
      3'b010: return OP_SLT;
      3'b011: return OP_SLTU;
      3'b100: return OP_XOR;
      3'b101: return OP_SRL;
      3'b110: return OP_OR;
      3'b111: return OP_AND;
    endcase
  endfunction

  function automatic op_e m_op(input logic [2:0] f3);
    unique case (f3)
      3'b000: return OP_MUL;
      3'b001: return OP_MULH;
      3'b010: return OP_MULHSU;
      3'b011: return OP_MULHU;
      3'b100: return OP_DIV;
      3'b101: return OP_DIVU;
      3'b110: return OP_REM;
      3'b111: return OP_REMU;
    endcase
  endfunction

  state_e state_q;
  op_e    op;

  logic            ready;
  logic            accept;
  logic [XLEN-1:0] res;
  logic            br;
  logic            ill;
  logic            slow;

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [SW-1:0]   cnt_q;
  logic            negq_q;
  logic            negr_q;
  logic            remsel_q;

  assign ready  = (state_q == S_IDLE) && (!oValid || iReady);
  assign oReady = ready;
  assign accept = iValid && ready && !iFlush;

  always_comb begin
    op = OP_ILL;
    unique case (iAluOp)
      3'b000, 3'b101: op = OP_ADD;
      3'b001: begin
        if (iFunct3[2:1] != 2'b01) op = OP_BR;
      end
      3'b010: begin
        if (iFunct7 == F7_BASE) begin
          op = base_op(iFunct3);
        end else if (iFunct7 == F7_ALT) begin
          if (iFunct3 == 3'b000) op = OP_SUB;
          else if (iFunct3 == 3'b101) op = OP_SRA;
        end else if (HAS_M && iFunct7 == F7_MUL) begin
          op = m_op(iFunct3);
        end
      end
      3'b011: begin
        op = base_op(iFunct3);
        if (iFunct3 == 3'b001 && iFunct7 != F7_BASE)
          op = OP_ILL;
        if (iFunct3 == 3'b101) begin
          if (iFunct7 == F7_BASE) op = OP_SRL;
          else if (iFunct7 == F7_ALT) op = OP_SRA;
          else op = OP_ILL;
        end
      end
      3'b100: op = OP_PASSB;
      default: op = OP_ILL;
    endcase
  end

  logic [SW-1:0]     shamt;
  logic [XLEN-1:0]   sum;
  logic [XLEN-1:0]   diff;
  logic [XLEN-1:0]   sra_v;
  logic              eq;
  logic              lt;
  logic              ltu;
  logic              taken;
  logic              a_sx;
  logic              b_sx;
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] prod;

  assign shamt = iOpB[SW-1:0];
  assign sum   = iOpA + iOpB;
  assign diff  = iOpA - iOpB;
  assign sra_v = $unsigned($signed(iOpA) >>> shamt);
  assign eq    = (iOpA == iOpB);
  assign lt    = ($signed(iOpA) < $signed(iOpB));
  assign ltu   = (iOpA < iOpB);

  // Extending both operands to 2*XLEN makes one unsigned multiply
  // serve all four signedness variants modulo 2^(2*XLEN).
  assign a_sx  = (op == OP_MULH || op == OP_MULHSU) && iOpA[XLEN-1];
  assign b_sx  = (op == OP_MULH) && iOpB[XLEN-1];
  assign mul_a = {{XLEN{a_sx}}, iOpA};
  assign mul_b = {{XLEN{b_sx}}, iOpB};
  assign prod  = mul_a * mul_b;

  always_comb begin
    taken = 1'b0;
    case (iFunct3)
      3'b000:  taken = eq;
      3'b001:  taken = !eq;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  logic            dsgn;
  logic            b_zero;
  logic            d_ovf;
  logic [XLEN-1:0] fast_q;
  logic [XLEN-1:0] fast_r;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  assign dsgn   = (op == OP_DIV) || (op == OP_REM);
  assign b_zero = (iOpB == '0);
  assign d_ovf  = dsgn && (iOpA == MIN_NEG) && (iOpB == '1);
  assign fast_q = b_zero ? '1 : iOpA;
  assign fast_r = b_zero ? iOpA : '0;
  assign a_mag  = (dsgn && iOpA[XLEN-1]) ? -iOpA : iOpA;
  assign b_mag  = (dsgn && iOpB[XLEN-1]) ? -iOpB : iOpB;

  always_comb begin
    res  = '0;
    br   = 1'b0;
    ill  = 1'b0;
    slow = 1'b0;
    case (op)
      OP_ADD:    res = sum;
      OP_SUB:    res = diff;
      OP_SLL:    res = iOpA << shamt;
      OP_SLT:    res = {{(XLEN-1){1'b0}}, lt};
      OP_SLTU:   res = {{(XLEN-1){1'b0}}, ltu};
      OP_XOR:    res = iOpA ^ iOpB;
      OP_SRL:    res = iOpA >> shamt;
      OP_SRA:    res = sra_v;
      OP_OR:     res = iOpA | iOpB;
      OP_AND:    res = iOpA & iOpB;
      OP_PASSB:  res = iOpB;
      OP_MUL:    res = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  res = prod[2*XLEN-1:XLEN];
      OP_DIV,
      OP_DIVU: begin
        res  = fast_q;
        slow = !(b_zero || d_ovf);
      end
      OP_REM,
      OP_REMU: begin
        res  = fast_r;
        slow = !(b_zero || d_ovf);
      end
      OP_BR:     br = taken;
      default:   ill = 1'b1;
    endcase
  end

  // One restoring step; the shifted partial remainder needs XLEN+1
  // bits because an unsigned divisor may use the full width.
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;
  logic [XLEN-1:0] div_res;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});
  assign rem_nx  = ge ? shifted[XLEN-1:0] - dvs_q : shifted[XLEN-1:0];
  assign quo_nx  = {quo_q[XLEN-2:0], ge};
  assign q_fin   = negq_q ? -quo_nx : quo_nx;
  assign r_fin   = negr_q ? -rem_nx : rem_nx;
  assign div_res = remsel_q ? r_fin : q_fin;

  logic div_last;
  assign div_last = (state_q == S_DIV) && (cnt_q == '1);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q      <= S_IDLE;
      oValid       <= 1'b0;
      oResult      <= '0;
      oBranchTaken <= 1'b0;
      oIllegal     <= 1'b0;
    end else if (iFlush) begin
      state_q <= S_IDLE;
      oValid  <= 1'b0;
    end else if (accept && !slow) begin
      oValid       <= 1'b1;
      oResult      <= res;
      oBranchTaken <= br;
      oIllegal     <= ill;
    end else if (accept) begin
      state_q <= S_DIV;
      oValid  <= 1'b0;
    end else if (div_last) begin
      state_q      <= S_IDLE;
      oValid       <= 1'b1;
      oResult      <= div_res;
      oBranchTaken <= 1'b0;
      oIllegal     <= 1'b0;
    end else if (iReady) begin
      oValid <= 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      remsel_q <= 1'b0;
    end else if (accept && slow) begin
      rem_q    <= '0;
      quo_q    <= a_mag;
      dvs_q    <= b_mag;
      cnt_q    <= '0;
      negq_q   <= dsgn && (iOpA[XLEN-1] ^ iOpB[XLEN-1]);
      negr_q   <= dsgn && iOpA[XLEN-1];
      remsel_q <= (op == OP_REM) || (op == OP_REMU);
    end else if (state_q == S_DIV && !iFlush) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors in, a separate
// monitor pops expected results and checks value and arrival cycle.
module tb_alu_exec_unit;

  logic        iClk = 1'b0;
  logic        iRstN = 1'b0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [2:0]  iAluOp = '0;
  logic [2:0]  iFunct3 = '0;
  logic [6:0]  iFunct7 = '0;
  logic [31:0] iOpA = '0;
  logic [31:0] iOpB = '0;
  logic        iFlush = 1'b0;
  logic        oValid;
  logic        iReady = 1'b1;
  logic [31:0] oResult;
  logic        oBranchTaken;
  logic        oIllegal;

  logic        nm_ready;
  logic        nm_valid;
  logic [31:0] nm_result;
  logic        nm_br;
  logic        nm_ill;

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1)) dut (
    .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
    .iAluOp(iAluOp), .iFunct3(iFunct3), .iFunct7(iFunct7),
    .iOpA(iOpA), .iOpB(iOpB), .iFlush(iFlush), .oValid(oValid),
    .iReady(iReady), .oResult(oResult), .oBranchTaken(oBranchTaken),
    .oIllegal(oIllegal)
  );

  alu_exec_unit #(.XLEN(32), .ENABLE_M(0)) u_nom (
    .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(nm_ready),
    .iAluOp(iAluOp), .iFunct3(iFunct3), .iFunct7(iFunct7),
    .iOpA(iOpA), .iOpB(iOpB), .iFlush(iFlush), .oValid(nm_valid),
    .iReady(iReady), .oResult(nm_result), .oBranchTaken(nm_br),
    .oIllegal(nm_ill)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        br;
    logic        ill;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    bit   seen;
    int   first_cyc;
    seen = 0;
    first_cyc = 0;
    forever begin
      @(negedge iClk);
      if (!oValid) seen = 0;
      if (oValid && !seen) begin
        seen = 1;
        first_cyc = cyc;
      end
      if (oValid && iReady) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected: got res=%h with empty queue", oResult);
        end else begin
          e = sb.pop_front();
          if (oResult !== e.res || oBranchTaken !== e.br ||
              oIllegal !== e.ill) begin
            n_bad++;
            $display("FAIL %s: got res=%h br=%b ill=%b want res=%h br=%b ill=%b",
                     e.name, oResult, oBranchTaken, oIllegal,
                     e.res, e.br, e.ill);
          end
          n_cmp++;
          if (first_cyc != e.due) begin
            n_bad++;
            $display("FAIL %s_latency: got cycle %0d want %0d",
                     e.name, first_cyc, e.due);
          end
        end
        seen = 0;
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] op,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic bt,
                       input logic il, input bit slow);
    exp_t e;
    int   n;
    iAluOp = op; iFunct3 = f3; iFunct7 = f7;
    iOpA = a; iOpB = b; iValid = 1'b1;
    n = 0;
    while (!oReady && n < 100) begin
      @(posedge iClk); #1;
      n++;
    end
    if (!oReady) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: oReady timeout", nm);
      iValid = 1'b0;
      return;
    end
    @(posedge iClk); #1;
    iValid = 1'b0;
    e.name = nm; e.res = r; e.br = bt; e.ill = il;
    e.due = cyc + (slow ? 32 : 0);
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge iClk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  localparam logic [2:0] A_ADD = 3'b000, A_BR = 3'b001, A_R = 3'b010,
                         A_I = 3'b011, A_LUI = 3'b100, A_AUI = 3'b101;
  localparam logic [6:0] F0 = 7'h00, F20 = 7'h20, FM = 7'h01;

  initial begin : stim
    bit vseen;
    repeat (3) @(posedge iClk);
    #1 iRstN = 1'b1;
    #1;
    chk("rst_valid", {31'b0, oValid}, 32'd0);
    chk("rst_ready", {31'b0, oReady}, 32'd1);
    chk("rst_result", oResult, 32'd0);
    chk("rst_branch", {31'b0, oBranchTaken}, 32'd0);
    chk("rst_illegal", {31'b0, oIllegal}, 32'd0);
    @(posedge iClk); #1;

    issue("add_wrap", A_ADD, 3'd0, F0, 32'hFFFFFFFF, 32'd1, 32'h0, 0, 0, 0);
    issue("sub", A_R, 3'd0, F20, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 0, 0);
    issue("sra", A_R, 3'd5, F20, 32'h80000000, 32'd4, 32'hF8000000, 0, 0, 0);
    issue("sll_mask", A_R, 3'd1, F0, 32'd1, 32'h25, 32'h20, 0, 0, 0);
    issue("slt", A_R, 3'd2, F0, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0);
    issue("sltu", A_R, 3'd3, F0, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, 0);
    issue("xor", A_R, 3'd4, F0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0);
    issue("or", A_R, 3'd6, F0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0);
    issue("and", A_R, 3'd7, F0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0);
    issue("srl", A_R, 3'd5, F0, 32'h80000000, 32'd4, 32'h08000000, 0, 0, 0);
    issue("srai", A_I, 3'd5, F20, 32'h80000000, 32'h404, 32'hF8000000, 0, 0, 0);
    issue("addi_f7", A_I, 3'd0, 7'h7F, 32'd10, 32'hFFFFFFFF, 32'd9, 0, 0, 0);
    issue("lui", A_LUI, 3'd0, F0, 32'd99, 32'h12345000, 32'h12345000, 0, 0, 0);
    issue("auipc", A_AUI, 3'd0, F0, 32'h1000, 32'h2000, 32'h3000, 0, 0, 0);

    issue("mul", A_R, 3'd0, FM, 32'd6, 32'd7, 32'd42, 0, 0, 0);
    @(negedge iClk);
    chk("nom_mul_ill", {31'b0, nm_ill}, 32'd1);
    chk("nom_mul_res", nm_result, 32'd0);
    @(posedge iClk); #1;
    issue("mulh", A_R, 3'd1, FM, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0, 0);
    issue("mulhsu", A_R, 3'd2, FM, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    issue("mulhu", A_R, 3'd3, FM, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0);

    issue("div_neg", A_R, 3'd4, FM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, 0, 1);
    issue("rem_neg", A_R, 3'd6, FM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0, 0, 1);
    issue("div_negb", A_R, 3'd4, FM, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0, 1);
    issue("rem_negb", A_R, 3'd6, FM, 32'd7, 32'hFFFFFFFE, 32'd1, 0, 0, 1);
    issue("divu", A_R, 3'd5, FM, 32'd100, 32'd7, 32'd14, 0, 0, 1);
    issue("remu", A_R, 3'd7, FM, 32'd100, 32'd7, 32'd2, 0, 0, 1);
    issue("divu_big", A_R, 3'd5, FM, 32'hFFFFFFFF, 32'h80000001, 32'd1, 0, 0, 1);
    issue("remu_big", A_R, 3'd7, FM, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 0, 0, 1);
    issue("divu_zero", A_R, 3'd5, FM, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 0, 0);
    issue("remu_zero", A_R, 3'd7, FM, 32'd5, 32'd0, 32'd5, 0, 0, 0);
    issue("div_ovf", A_R, 3'd4, FM, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 0);
    issue("rem_ovf", A_R, 3'd6, FM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, 0, 0);

    issue("bltu", A_BR, 3'd6, F0, 32'd1, 32'hFFFFFFFF, 32'd0, 1, 0, 0);
    issue("blt", A_BR, 3'd4, F0, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 0, 0);
    issue("beq", A_BR, 3'd0, F0, 32'd5, 32'd5, 32'd0, 1, 0, 0);
    issue("bne", A_BR, 3'd1, F0, 32'd5, 32'd5, 32'd0, 0, 0, 0);
    issue("bge", A_BR, 3'd5, F0, 32'd1, 32'hFFFFFFFF, 32'd0, 1, 0, 0);
    issue("bgeu", A_BR, 3'd7, F0, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 0, 0);
    issue("br_f3_2", A_BR, 3'd2, F0, 32'd1, 32'd1, 32'd0, 0, 1, 0);
    issue("r_f7_02", A_R, 3'd0, 7'h02, 32'd3, 32'd4, 32'd0, 0, 1, 0);
    issue("r_alt_sll", A_R, 3'd1, F20, 32'd3, 32'd4, 32'd0, 0, 1, 0);
    issue("slli_f7", A_I, 3'd1, F20, 32'd3, 32'h401, 32'd0, 0, 1, 0);
    issue("aluop_110", 3'b110, 3'd0, F0, 32'd3, 32'd4, 32'd0, 0, 1, 0);
    drain();

    iReady = 1'b0;
    issue("bp_add", A_ADD, 3'd0, F0, 32'd10, 32'd20, 32'd30, 0, 0, 0);
    iAluOp = A_R; iFunct3 = 3'd4; iFunct7 = F0;
    iOpA = 32'h0F; iOpB = 32'hFF; iValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      chk("bp_hold_res", oResult, 32'd30);
      chk("bp_ready", {31'b0, oReady}, 32'd0);
    end
    @(posedge iClk); #1;
    iReady = 1'b1;
    #1 chk("bp_release_ready", {31'b0, oReady}, 32'd1);
    @(posedge iClk); #1;
    iValid = 1'b0;
    sb.push_back('{name: "bp_xor", res: 32'hF0, br: 1'b0, ill: 1'b0, due: cyc});
    drain();

    issue("flush_div", A_R, 3'd4, FM, 32'd1000, 32'd3, 32'd333, 0, 0, 1);
    repeat (5) @(posedge iClk);
    #1;
    void'(sb.pop_back());
    iFlush = 1'b1;
    iAluOp = A_ADD; iOpA = 32'd1; iOpB = 32'd1; iValid = 1'b1;
    @(posedge iClk); #1;
    iFlush = 1'b0; iValid = 1'b0;
    chk("flush_ready", {31'b0, oReady}, 32'd1);
    vseen = 0;
    repeat (40) begin
      @(negedge iClk);
      if (oValid) vseen = 1;
    end
    chk("flush_no_valid", {31'b0, vseen}, 32'd0);
    @(posedge iClk); #1;

    issue("rst_div", A_R, 3'd5, FM, 32'd1000, 32'd3, 32'd333, 0, 0, 1);
    repeat (10) @(posedge iClk);
    #1 iRstN = 1'b0;
    void'(sb.pop_back());
    #1 chk("rst_mid_valid", {31'b0, oValid}, 32'd0);
    @(posedge iClk); #1;
    iRstN = 1'b1;
    #1;
    chk("rst_mid_ready", {31'b0, oReady}, 32'd1);
    chk("rst_mid_valid2", {31'b0, oValid}, 32'd0);
    issue("add_after_rst", A_ADD, 3'd0, F0, 32'd3, 32'd4, 32'd7, 0, 0, 0);
    drain();
    repeat (2) @(posedge iClk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
